// File: rtl/count_capture_pkg.sv
// ---------------------------------------------------------------------------
// count_capture_pkg
// Shared types and helpers for the count_capture block.
//   stat_cnt_t : 16-bit status counter type (drop and step-error counts)
//   STAT_MAX   : saturation value of a status counter
//   ptr_w()    : FIFO pointer width, one wrap bit above the index bits
//   sat_inc()  : saturating increment for status counters
// ---------------------------------------------------------------------------
package count_capture_pkg;

    typedef logic [15:0] stat_cnt_t;

    localparam stat_cnt_t STAT_MAX = 16'hFFFF;

    // The extra MSB lets full and empty be told apart when the index bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Status counters stick at all-ones instead of wrapping back to zero.
    function automatic stat_cnt_t sat_inc(input stat_cnt_t value);
        return (value == STAT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/count_capture_fifo.sv
// ---------------------------------------------------------------------------
// count_capture_fifo
// Synchronous FIFO with a registered head-of-queue output.
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   internal active-low reset (pointers and output register)
//   push       in   write request; taken when not full or when popping
//   push_data  in   WIDTH-bit data to write
//   pop        in   read request; taken when not empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   out_data   out  registered copy of the oldest entry (0 after reset)
// ---------------------------------------------------------------------------
module count_capture_fifo
    import count_capture_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_nxt;
    logic [PTR_W-1:0] rd_nxt;
    logic             do_push;
    logic             do_pop;
    logic             next_empty;
    logic [WIDTH-1:0] head_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // A push into a full FIFO is only legal when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_nxt     = wr_ptr + PTR_W'(do_push);
    assign rd_nxt     = rd_ptr + PTR_W'(do_pop);
    assign next_empty = (wr_nxt == rd_nxt);

    // The only way the slot being written becomes the new head is when the
    // FIFO holds exactly one entry afterwards, so forward the push data then.
    assign head_next = (do_push && (wr_ptr[IDX_W-1:0] == rd_nxt[IDX_W-1:0]))
                     ? push_data : mem[rd_nxt[IDX_W-1:0]];

    // Storage is deliberately left without reset; only the pointers define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // Pointers wrap modulo 2*DEPTH naturally through their extra MSB. The
    // output register follows the head so the consumer sees a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_data <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if ((do_push || do_pop) && !next_empty) begin
                out_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/count_capture.sv
// ---------------------------------------------------------------------------
// count_capture
// Snapshots the upstream counter on trig, buffers snapshots in a FIFO and
// streams them out over valid/ready. Counts triggers lost to a full FIFO.
// Optional feature macro: COUNT_CHECK_EN enables a step checker that counts
// cycles where cnt_in did not advance by exactly one.
// Ports:
//   clk         in   clock, all logic on posedge
//   reset_n_in  in   asynchronous active-low reset, released through 2 flops
//   cnt_in      in   WIDTH-bit counter value, one per cycle
//   load_in     in   upstream load strobe (used by the step checker only)
//   trig        in   capture cnt_in this cycle
//   m_valid     out  snapshot available on m_data
//   m_ready     in   consumer accepts when m_valid && m_ready
//   m_data      out  oldest buffered snapshot
//   ovf         out  sticky flag, at least one trigger dropped
//   clr_ovf     in   clears ovf, drop_cnt and err_cnt
//   drop_cnt    out  saturating count of dropped triggers
//   err_cnt     out  saturating count of step errors (0 without the checker)
// ---------------------------------------------------------------------------
module count_capture
    import count_capture_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n_in,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             load_in,
    input  logic             trig,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      err_cnt
);

    logic [1:0] reset_sync;
    logic       rst_n;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       drop;

    // Reset asserts immediately but is released only after two clean clock
    // edges so every downstream flop leaves reset in the same cycle.
    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            reset_sync <= 2'b00;
        end else begin
            reset_sync <= {reset_sync[0], 1'b1};
        end
    end

    assign rst_n = reset_sync[1];

    // m_valid comes straight from the pointer registers, never from m_ready.
    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign drop    = trig && fifo_full && !pop;

    count_capture_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (trig),
        .push_data (cnt_in),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .out_data  (m_data)
    );

    // A drop in the same cycle as a clear wins, so the lost sample is never
    // silently hidden by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= clr_ovf ? 16'd1 : sat_inc(drop_cnt);
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef COUNT_CHECK_EN
    logic [WIDTH-1:0] prev_cnt;
    logic             primed;
    logic             load_d1;
    logic             load_d2;
    logic             step_err;
    stat_cnt_t        err_q;

    // A load reaches cnt_in through the upstream input register and the
    // counter itself, so the two cycles after a load may legally jump.
    assign step_err = primed && !load_d1 && !load_d2 &&
                      (cnt_in != prev_cnt + WIDTH'(1));

    // Track the previous count and tally unexpected steps; all-ones to zero
    // falls out of the modular add and is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt <= '0;
            primed   <= 1'b0;
            load_d1  <= 1'b0;
            load_d2  <= 1'b0;
            err_q    <= '0;
        end else begin
            prev_cnt <= cnt_in;
            primed   <= 1'b1;
            load_d1  <= load_in;
            load_d2  <= load_d1;
            if (step_err) begin
                err_q <= clr_ovf ? 16'd1 : sat_inc(err_q);
            end else if (clr_ovf) begin
                err_q <= '0;
            end
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_load;

    assign unused_load = load_in;
    assign err_cnt     = 16'd0;
`endif

endmodule

// File: tb/tb_count_capture.sv
// ---------------------------------------------------------------------------
// tb_count_capture
// Directed bench for count_capture. The stimulus task records every sample
// the FIFO is expected to accept in a queue; a negedge monitor pops and
// compares whenever a beat is handed over, and also tracks m_valid and
// stall stability independently of the stimulus thread.
// ---------------------------------------------------------------------------
module tb_count_capture;

    localparam int WIDTH = 64;
    localparam int DEPTH = 8;

    logic             clk;
    logic             reset_n_in;
    logic [WIDTH-1:0] cnt_in;
    logic             load_in;
    logic             trig;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             ovf;
    logic             clr_ovf;
    logic [15:0]      drop_cnt;
    logic [15:0]      err_cnt;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               model_occ = 0;
    bit               in_reset = 0;
    int               sync_wait = 0;
    bit               mon_en = 0;
    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_data = '0;

    count_capture #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n_in (reset_n_in),
        .cnt_in     (cnt_in),
        .load_in    (load_in),
        .trig       (trig),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: bump the counters and report any difference.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, predict acceptance, then step past the edge.
    task automatic applyStimulus(input logic t, input logic [WIDTH-1:0] c,
                                 input logic r, input logic clr, input logic ld);
        bit do_pop;
        bit do_push;
        trig    = t;
        cnt_in  = c;
        m_ready = r;
        clr_ovf = clr;
        load_in = ld;
        do_pop  = 0;
        do_push = 0;
        if (!in_reset && sync_wait == 0) begin
            do_pop  = (model_occ > 0) && r;
            do_push = t && ((model_occ < DEPTH) || do_pop);
            if (do_push) exp_q.push_back(c);
        end
        @(posedge clk);
        #1;
        model_occ = model_occ + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        if (!in_reset && sync_wait > 0) sync_wait--;
    endtask

    task automatic assertReset();
        reset_n_in = 1'b0;
        in_reset   = 1;
        exp_q.delete();
        model_occ  = 0;
    endtask

    task automatic releaseReset();
        reset_n_in = 1'b1;
        in_reset   = 0;
        sync_wait  = 2;
    endtask

    // Monitor: runs on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("mon_valid", 64'(m_valid), 64'(model_occ != 0));
            if (prev_stall) begin
                checkOutput("mon_stall_valid", 64'(m_valid), 1);
                checkOutput("mon_stall_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("mon_unexpected_beat", m_data, 64'hDEAD_BEEF);
                end else begin
                    checkOutput("mon_beat_data", m_data, exp_q.pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset_n_in = 1'b1;
        trig       = 1'b0;
        cnt_in     = '0;
        m_ready    = 1'b0;
        clr_ovf    = 1'b0;
        load_in    = 1'b0;
        #2;
        assertReset();
        @(posedge clk);
        #1;
        mon_en = 1;

        $display("[TB] reset hold with trig active");
        for (int i = 0; i < 5; i++) applyStimulus(1, 64'(i + 1), 1, 0, 0);
        checkOutput("rst_m_valid", 64'(m_valid), 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_ovf", 64'(ovf), 0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 0);
        releaseReset();
        applyStimulus(1, 7, 1, 0, 0);
        applyStimulus(1, 8, 1, 0, 0);
        checkOutput("sync_no_valid", 64'(m_valid), 0);
        applyStimulus(1, 9, 1, 0, 0);
        checkOutput("first_valid", 64'(m_valid), 1);
        checkOutput("first_data", m_data, 9);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("first_gone", 64'(m_valid), 0);

        $display("[TB] single capture");
        applyStimulus(1, 100, 1, 0, 0);
        checkOutput("single_valid", 64'(m_valid), 1);
        checkOutput("single_data", m_data, 100);
        applyStimulus(0, 100, 1, 0, 0);
        checkOutput("single_one_cycle", 64'(m_valid), 0);

        $display("[TB] backpressure");
        for (int i = 0; i < 8; i++) applyStimulus(1, 64'(10 + i), 0, 0, 0);
        checkOutput("bp_valid", 64'(m_valid), 1);
        checkOutput("bp_head", m_data, 10);
        checkOutput("bp_ovf", 64'(ovf), 0);
        checkOutput("bp_drop_cnt", 64'(drop_cnt), 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("bp_drained", 64'(m_valid), 0);

        $display("[TB] overflow");
        for (int i = 0; i < 11; i++) applyStimulus(1, 64'(20 + i), 0, 0, 0);
        checkOutput("ovf_set", 64'(ovf), 1);
        checkOutput("ovf_drop_cnt", 64'(drop_cnt), 3);
        checkOutput("ovf_head", m_data, 20);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("clr_ovf", 64'(ovf), 0);
        checkOutput("clr_drop_cnt", 64'(drop_cnt), 0);
        applyStimulus(1, 31, 1, 0, 0);
        checkOutput("full_pop_no_ovf", 64'(ovf), 0);
        checkOutput("full_pop_no_drop", 64'(drop_cnt), 0);
        checkOutput("full_pop_head", m_data, 21);
        applyStimulus(1, 32, 0, 1, 0);
        checkOutput("drop_beats_clr_ovf", 64'(ovf), 1);
        checkOutput("drop_beats_clr_cnt", 64'(drop_cnt), 1);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("ovf_drained", 64'(m_valid), 0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 4; i++) applyStimulus(1, 64'(40 + i), 0, 0, 0);
        checkOutput("mid_valid_before", 64'(m_valid), 1);
        #2;
        assertReset();
        mon_en = 0;
        #1;
        checkOutput("mid_valid_async", 64'(m_valid), 0);
        checkOutput("mid_data_async", m_data, 0);
        @(posedge clk);
        #1;
        mon_en = 1;
        for (int i = 0; i < 3; i++) applyStimulus(1, 60, 1, 0, 0);
        releaseReset();
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("mid_empty_after", 64'(m_valid), 0);
        applyStimulus(1, 50, 1, 0, 0);
        checkOutput("mid_resume_valid", 64'(m_valid), 1);
        checkOutput("mid_resume_data", m_data, 50);
        applyStimulus(0, 0, 1, 0, 0);

`ifdef COUNT_CHECK_EN
        $display("[TB] step checker");
        applyStimulus(0, 3, 1, 0, 0);
        applyStimulus(0, 4, 1, 1, 0);
        checkOutput("chk_cleared", 64'(err_cnt), 0);
        applyStimulus(0, 5, 1, 0, 0);
        applyStimulus(0, 6, 1, 0, 0);
        applyStimulus(0, 9, 1, 0, 0);
        checkOutput("chk_step_err", 64'(err_cnt), 1);
        applyStimulus(0, 10, 1, 0, 1);
        applyStimulus(0, 77, 1, 0, 0);
        applyStimulus(0, 500, 1, 0, 0);
        applyStimulus(0, 501, 1, 0, 0);
        applyStimulus(0, 502, 1, 0, 0);
        checkOutput("chk_load_masked", 64'(err_cnt), 1);
        applyStimulus(0, 503, 1, 0, 1);
        applyStimulus(0, 999, 1, 0, 0);
        applyStimulus(0, '1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("chk_wrap_legal", 64'(err_cnt), 1);
        applyStimulus(0, 5, 1, 0, 0);
        checkOutput("chk_second_err", 64'(err_cnt), 2);
`else
        $display("[TB] err_cnt tied off");
        applyStimulus(0, 3, 1, 0, 0);
        applyStimulus(0, 9, 1, 0, 1);
        applyStimulus(0, 2, 1, 0, 0);
        checkOutput("err_cnt_tied", 64'(err_cnt), 0);
`endif

        checkOutput("sb_all_consumed", 64'(exp_q.size()), 0);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
